seq_divider: RTL
================

# seq_divider

Multi-cycle unsigned integer divider built on a single shared trial subtractor, one quotient bit per clock (restoring algorithm). It sits beside the combinational add/subtract datapath in the ALU, serving DIV/REM operations through a start/busy/done handshake. Operands and results are WIDTH bits. Divide-by-zero and signed overflow are flagged rather than trapped.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- dividend_i  in  WIDTH  dividend, latched on accepted start
- divisor_i  in  WIDTH  divisor, latched on accepted start
- busy_o  out  1  high in CALC and DONE
- done_o  out  1  one-cycle pulse; results valid
- quotient_o  out  WIDTH  quotient, held until next accepted start
- remainder_o  out  WIDTH  remainder, held until next accepted start
- div_by_zero_o  out  1  divisor was zero; held with results
- ovf_o  out  1  signed overflow; held with results (0 when signed mode absent)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start_i=1 at an edge → latch operands, clear div_by_zero_o/ovf_o, load R=0 (WIDTH+1 bits), Q=dividend, iteration counter=0; go CALC. If latched divisor==0 → go DONE directly, quotient_o=all ones, remainder_o=dividend, div_by_zero_o=1.
- CALC, each edge: {R,Q} <<= 1; T = R − {0,divisor} (WIDTH+1 bits); if T MSB==0 then R=T, Q[0]=1 else Q[0]=0 (R unchanged). Counter increments; after WIDTH iterations go DONE, load quotient_o=Q, remainder_o=R[WIDTH-1:0].
- DONE: done_o=1 for exactly one cycle; next edge → IDLE.
- start_i while in CALC or DONE is ignored (no queuing); a request must be re-presented in IDLE.
- Operand inputs are don't-care except at the accepting edge.
- Result invariant (unsigned): dividend = quotient·divisor + remainder, remainder < divisor.

## Timing
- Reset (any time, including mid-CALC): state=IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0, ovf_o=0; aborted operation produces no done pulse.
- Normal latency: start accepted at edge E0; done_o high in the cycle after edge E(WIDTH) (WIDTH+1 cycles after acceptance; 9 for WIDTH=8); IDLE after E(WIDTH+1).
- Divide-by-zero latency: done_o high in the cycle after E0.
- Back-to-back throughput: next start accepted at E(WIDTH+2) earliest (start_i held high from DONE is accepted then).
- busy_o rises after E0, falls after the DONE→IDLE edge.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined: operands are two's complement. On accept, magnitudes are taken; core runs unsigned; on entry to DONE the quotient is negated if operand signs differ, remainder takes the dividend's sign (truncation toward zero). Most-negative ÷ −1 → quotient=most-negative (wrapped), remainder=0, ovf_o=1. Divide-by-zero: quotient=all ones, remainder=dividend, div_by_zero_o=1. Latency unchanged.
- Undefined: unsigned only; ovf_o tied 0; no sign logic synthesized.

## Structure
- Package div_pkg: state enum typedef (IDLE/CALC/DONE), default width constant, counter width as $clog2(WIDTH+1).
- Sub-module div_trial_sub: (WIDTH+1)-bit combinational subtractor returning difference and borrow (difference MSB); one instance.
- Top holds FSM, counter, R/Q registers, result/flag registers, optional sign fix-up.

## Test plan
- 100 ÷ 7 (WIDTH=8) → quotient 14, remainder 2, done_o exactly 9 cycles after accepting edge, flags 0.
- 255 ÷ 1 then 3 ÷ 200 back-to-back → 255/0, then 0/3; second start accepted only in IDLE.
- 5 ÷ 0 → quotient 0xFF, remainder 5, div_by_zero_o=1, done_o 1 cycle after accept.
- start_i pulsed mid-CALC with different operands → ignored; first result unchanged, single done pulse.
- rst_i asserted at iteration 4 → all outputs 0 immediately, no done_o; fresh 9 ÷ 3 after release → 3/0.
- SEQ_DIVIDER_SIGNED_EN: −7 ÷ 2 → 0xFD/0xFF; 7 ÷ −2 → 0xFD/0x01; −128 ÷ −1 → 0x80/0x00, ovf_o=1.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider:
//                FSM state encoding, default operand width and the
//                iteration-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Operand/result width used when the parent does not override WIDTH
    localparam int DIV_WIDTH_DEFAULT = 8;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter must hold the values 0..WIDTH
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : div_trial_sub
//  Description : (WIDTH+1)-bit combinational trial subtractor for the
//                restoring divider. The difference MSB doubles as the borrow:
//                a set MSB means the partial remainder was smaller than the
//                divisor and must be restored.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_trial_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0] minuend_i,
    input  logic [WIDTH:0] subtrahend_i,
    output logic [WIDTH:0] diff_o,
    output logic           borrow_o
);

    assign diff_o   = minuend_i - subtrahend_i;
    assign borrow_o = diff_o[WIDTH];

endmodule : div_trial_sub
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle restoring integer divider, one quotient bit per
//                clock through a single shared trial subtractor.
//                start/busy/done handshake; divide-by-zero and signed
//                overflow are reported as flags held with the results.
//                Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//                  defined   -> two's complement operands, truncating
//                               division, overflow flag on MIN / -1
//                  undefined -> unsigned only, ovf_o tied low
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic             ovf_o
);

    localparam int              CNT_W     = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;           // partial remainder R
    logic [WIDTH-1:0] quo_q, quo_d;           // shifting dividend / quotient Q
    logic [WIDTH-1:0] dsr_q, dsr_d;           // latched divisor magnitude
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_dsr_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH-1:0] w_quo_final;
    logic [WIDTH-1:0] w_rem_final;
    logic             w_ovf_final;

    assign w_accept   = (state_q == IDLE) && start_i;
    assign w_dsr_zero = (divisor_i == '0);
    assign w_last     = (cnt_q == LAST_ITER);

    // {R,Q} shifted left by one: top dividend bit enters the remainder
    assign w_shift_rem = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .minuend_i    (w_shift_rem),
        .subtrahend_i ({1'b0, dsr_q}),
        .diff_o       (w_trial),
        .borrow_o     (w_borrow)
    );

    // Keep the difference only when it did not go negative
    assign w_rem_next = w_borrow ? w_shift_rem : w_trial;
    assign w_quo_next = {quo_q[WIDTH-2:0], ~w_borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
    // ------------------------------------------------------------------
    // Signed operation: core divides magnitudes, signs restored at the end
    // ------------------------------------------------------------------
    logic w_dvd_neg;
    logic w_dsr_neg;
    logic w_ovf_acc;
    logic neg_quo_q;
    logic neg_rem_q;
    logic ovf_pend_q;

    assign w_dvd_neg = dividend_i[WIDTH-1];
    assign w_dsr_neg = divisor_i[WIDTH-1];
    // MIN magnitude wraps back to MIN, which is still correct read unsigned
    assign w_dvd_mag = w_dvd_neg ? (-dividend_i) : dividend_i;
    assign w_dsr_mag = w_dsr_neg ? (-divisor_i)  : divisor_i;
    // Most-negative / -1 is the only result that does not fit
    assign w_ovf_acc = (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor_i);

    // Capture sign fix-up decisions with the operands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (w_accept) begin
            neg_quo_q  <= w_dvd_neg ^ w_dsr_neg;
            neg_rem_q  <= w_dvd_neg;
            ovf_pend_q <= w_ovf_acc;
        end
    end

    // Quotient negated on differing signs, remainder follows the dividend
    assign w_quo_final = neg_quo_q ? (-w_quo_next) : w_quo_next;
    assign w_rem_final = neg_rem_q ? (-w_rem_next[WIDTH-1:0]) : w_rem_next[WIDTH-1:0];
    assign w_ovf_final = ovf_pend_q;
`else
    assign w_dvd_mag   = dividend_i;
    assign w_dsr_mag   = divisor_i;
    assign w_quo_final = w_quo_next;
    assign w_rem_final = w_rem_next[WIDTH-1:0];
    assign w_ovf_final = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: zero divisor skips the iteration phase entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = w_dsr_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Next values for the iteration registers and held results
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        if (w_accept) begin
            cnt_d = '0;
            rem_d = '0;
            quo_d = w_dvd_mag;
            dsr_d = w_dsr_mag;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (w_dsr_zero) begin
                quotient_d  = '1;
                remainder_d = dividend_i;
                dbz_d       = 1'b1;
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 1'b1;
            rem_d = w_rem_next;
            quo_d = w_quo_next;
            if (w_last) begin
                quotient_d  = w_quo_final;
                remainder_d = w_rem_final;
                ovf_d       = w_ovf_final;
            end
        end
    end

    // Datapath registers; reset clears every visible result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;
    assign ovf_o         = ovf_q;

endmodule : seq_divider
`default_nettype wire
